// File: rtl/obi_aer_bridge_pkg.sv
// Shared types and constants for the OBI-to-AER transmit bridge:
// bus payload structs, register map offsets, register bit positions, FSM states.
package obi_aer_bridge_pkg;

  localparam int unsigned OBI_AW = 32;
  localparam int unsigned OBI_DW = 32;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [3:0]        be;
    logic [OBI_AW-1:0] addr;
    logic [OBI_DW-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [OBI_DW-1:0] rdata;
  } obi_rsp_t;

  // Register select taken from addr[3:2]
  localparam logic [1:0] REG_EVENT  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_STALL   = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned CTRL_OVF_CLR = 3;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_LOW = 2'd2
  } aer_state_e;

endpackage

// File: rtl/aer_event_fifo.sv
// Synchronous event FIFO with occupancy count; a push while full is taken
// only when a pop happens in the same cycle.
module aer_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_aer_tx_bridge.sv
// OBI slave that buffers CPU-posted spike events and drains them over a
// 4-phase AER handshake with a synchronised acknowledge.
module obi_aer_tx_bridge
  import obi_aer_bridge_pkg::*;
#(
  parameter int unsigned AER_W       = 10,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter type         req_t       = obi_req_t,
  parameter type         rsp_t       = obi_rsp_t
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  req_t             obi_req_i,
  output rsp_t             obi_rsp_o,
  output logic [AER_W-1:0] aer_addr_o,
  output logic             aer_req_o,
  input  logic             aer_ack_i,
  output logic             irq_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  aer_state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_vld_q;
  logic                    ack_s, ack_vld;
  logic                    en_q, en_d, stall_q, stall_d, irq_en_q, irq_en_d;
  logic                    ovf_q, ovf_d, irq_q;
  logic                    aer_req_q, aer_req_d;
  logic [AER_W-1:0]        aer_addr_q, aer_addr_d;
  logic                    rvalid_q;
  logic [OBI_DW-1:0]       rdata_q, rdata_d, status_w;
  logic [1:0]              reg_sel;
  logic                    evt_wr, ctrl_wr, evt_blocked, gnt_c, ovf_set;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AER_W-1:0]        fifo_head;
  logic [CNT_W-1:0]        fifo_count;
  logic                    unused_bus;

  assign reg_sel     = obi_req_i.addr[3:2];
  assign evt_wr      = obi_req_i.req && obi_req_i.we && (reg_sel == REG_EVENT);
  assign ctrl_wr     = obi_req_i.req && obi_req_i.we && (reg_sel == REG_CTRL) && obi_req_i.be[0];
  assign evt_blocked = evt_wr && fifo_full && !fifo_pop;
  assign gnt_c       = obi_req_i.req && !(evt_blocked && stall_q);
  assign fifo_push   = evt_wr && !evt_blocked;
  assign ovf_set     = evt_blocked && !stall_q;
  assign unused_bus  = ^{obi_req_i.be, obi_req_i.addr, obi_req_i.wdata};

  aer_event_fifo #(
    .WIDTH (AER_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (obi_req_i.wdata[AER_W-1:0]),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ack_vld marks the synchroniser as refilled with real samples after reset
  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign ack_vld = sync_vld_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      sync_vld_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], aer_ack_i};
      sync_vld_q <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      aer_req_q  <= 1'b0;
      aer_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      aer_req_q  <= aer_req_d;
      aer_addr_q <= aer_addr_d;
    end
  end

  // A new request needs ack seen low in IDLE; a stuck-high ack blocks it
  always_comb begin
    state_d    = state_q;
    aer_req_d  = aer_req_q;
    aer_addr_d = aer_addr_q;
    fifo_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_q && !fifo_empty && ack_vld && !ack_s) begin
          aer_addr_d = fifo_head;
          aer_req_d  = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          fifo_pop  = 1'b1;
          aer_req_d = 1'b0;
          state_d   = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!ack_s) state_d = S_IDLE;
      end
      default: begin
        aer_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_comb begin
    status_w                             = '0;
    status_w[STAT_BUSY]                  = (state_q != S_IDLE) || !fifo_empty;
    status_w[STAT_FULL]                  = fifo_full;
    status_w[STAT_OVF]                   = ovf_q;
    status_w[STAT_CNT_LSB +: CNT_W]      = fifo_count;
  end

  // Register file; an overflow set outranks a same-cycle clear
  always_comb begin
    en_d     = en_q;
    stall_d  = stall_q;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    rdata_d  = '0;
    if (ctrl_wr) begin
      en_d     = obi_req_i.wdata[CTRL_EN];
      stall_d  = obi_req_i.wdata[CTRL_STALL];
      irq_en_d = obi_req_i.wdata[CTRL_IRQ_EN];
      if (obi_req_i.wdata[CTRL_OVF_CLR]) ovf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (gnt_c && !obi_req_i.we) begin
      case (reg_sel)
        REG_STATUS: rdata_d = status_w;
        REG_CTRL: begin
          rdata_d[CTRL_EN]     = en_q;
          rdata_d[CTRL_STALL]  = stall_q;
          rdata_d[CTRL_IRQ_EN] = irq_en_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q     <= 1'b0;
      stall_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      en_q     <= en_d;
      stall_q  <= stall_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      irq_q    <= ovf_d && irq_en_d;
      rvalid_q <= gnt_c;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = gnt_c;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
  end

  assign aer_req_o  = aer_req_q;
  assign aer_addr_o = aer_addr_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_obi_aer_tx_bridge.sv
// Scoreboard bench for obi_aer_tx_bridge: OBI driver, AER receiver model and
// an rvalid monitor, all checked against bench-side expectations.
module tb_obi_aer_tx_bridge;
  import obi_aer_bridge_pkg::*;

  localparam int unsigned AER_W = 10;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned SYNC  = 2;
  localparam logic [31:0] A_EVENT  = 32'h0;
  localparam logic [31:0] A_STATUS = 32'h4;
  localparam logic [31:0] A_CTRL   = 32'h8;
  localparam logic [31:0] A_RSVD   = 32'hC;

  logic             clk;
  logic             rst;
  obi_req_t         req;
  obi_rsp_t         rsp;
  logic [AER_W-1:0] aer_addr;
  logic             aer_req;
  logic             aer_ack;
  logic             irq;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int grant_cyc = 0;
  int n_deliv = 0;
  int rx_dly = -1;
  bit rx_pause = 0;
  bit rx_force = 0;
  bit lat_chk = 0;
  bit in_hs = 0;

  logic [31:0]      exp_rd_q[$];
  logic [AER_W-1:0] exp_aer[$];

  obi_aer_tx_bridge #(
    .AER_W       (AER_W),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .obi_req_i  (req),
    .obi_rsp_o  (rsp),
    .aer_addr_o (aer_addr),
    .aer_req_o  (aer_req),
    .aer_ack_i  (aer_ack),
    .irq_o      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected STATUS from the number of events accepted but not yet delivered
  function automatic logic [31:0] status_exp(input int pending, input bit ovf);
    logic [31:0] s;
    s = 32'(pending) << 8;
    if (ovf) s = s | 32'h4;
    if (pending == int'(DEPTH)) s = s | 32'h2;
    if (pending != 0) s = s | 32'h1;
    return s;
  endfunction

  task automatic obi_start(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req.req   = 1'b1;
    req.we    = we;
    req.be    = 4'hF;
    req.addr  = addr;
    req.wdata = wdata;
  endtask

  // Entered and left at a falling edge; the request is dropped once granted
  task automatic obi_finish(input logic [31:0] exp_rd, output bit granted);
    granted = 1'b0;
    for (int i = 0; i < 300 && !granted; i++) begin
      #1;
      if (rsp.gnt) begin
        granted = 1'b1;
        grant_cyc = cyc;
        exp_rd_q.push_back(exp_rd);
      end
      @(negedge clk);
    end
    req.req = 1'b0;
    if (!granted) chk("obi_grant_timeout", 32'(granted), 32'd1);
  endtask

  task automatic obi_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, output bit granted);
    obi_start(we, addr, wdata);
    obi_finish(exp_rd, granted);
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
    bit g;
    obi_xfer(1'b1, addr, data, 32'h0, g);
  endtask

  task automatic reg_read(input logic [31:0] addr, input logic [31:0] exp);
    bit g;
    obi_xfer(1'b0, addr, 32'h0, exp, g);
  endtask

  task automatic evt_write(input logic [AER_W-1:0] v, input bit accepted);
    bit g;
    obi_xfer(1'b1, A_EVENT, 32'(v), 32'h0, g);
    if (g && accepted) exp_aer.push_back(v);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (exp_aer.size() == 0 && !in_hs && !aer_req && !aer_ack) done = 1'b1;
    end
    chk({name, "_drain"}, 32'(done), 32'd1);
    repeat (SYNC + 3) @(negedge clk);
  endtask

  // Response monitor: every rvalid must match the oldest granted request
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rsp.rvalid) begin
        if (exp_rd_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_rd_q.pop_front();
          chk("rdata", rsp.rdata, e);
        end
      end
    end
  end

  // AER receiver: checks order, stability and handshake timing, drives ack
  initial begin
    int dly;
    int ack_cyc;
    logic [AER_W-1:0] cur;
    aer_ack = 1'b0;
    dly = 0;
    ack_cyc = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_hs = 1'b0;
        aer_ack = rx_force;
      end else begin
        if (aer_req && !in_hs) begin
          in_hs = 1'b1;
          cur = aer_addr;
          n_deliv++;
          if (exp_aer.size() == 0) chk("aer_req_unexpected", 32'd1, 32'd0);
          else chk("aer_addr", 32'(aer_addr), 32'(exp_aer.pop_front()));
          if (lat_chk) chk("req_rise_latency", 32'(cyc - grant_cyc), 32'd2);
          dly = (rx_dly >= 0) ? rx_dly : int'($urandom_range(0, 5));
        end else if (aer_req && in_hs) begin
          chk("aer_addr_stable", 32'(aer_addr), 32'(cur));
        end
        if (rx_force) aer_ack = 1'b1;
        else if (in_hs && aer_req && !aer_ack && !rx_pause) begin
          if (dly == 0) begin
            aer_ack = 1'b1;
            ack_cyc = cyc;
          end else dly--;
        end else if (aer_ack && !aer_req) begin
          if (in_hs) chk("req_fall_latency", 32'(cyc - ack_cyc), 32'(SYNC + 1));
          aer_ack = 1'b0;
          in_hs = 1'b0;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    chk("rst_aer_req", 32'(aer_req), 32'd0);
    chk("rst_aer_addr", 32'(aer_addr), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_gnt", 32'(rsp.gnt), 32'd0);
    chk("rst_rvalid", 32'(rsp.rvalid), 32'd0);
    chk("rst_rdata", rsp.rdata, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single event, fixed 3-cycle receiver, latency checks
    reg_read(A_CTRL, 32'h0);
    rx_dly = 3;
    lat_chk = 1'b1;
    reg_write(A_CTRL, 32'h1);
    evt_write(AER_W'(10'h2A5), 1'b1);
    wait_drain("single");
    lat_chk = 1'b0;
    rx_dly = -1;
    reg_read(A_STATUS, status_exp(0, 1'b0));

    // Register map corners
    reg_read(A_CTRL, 32'h1);
    reg_read(A_RSVD, 32'h0);
    reg_write(A_RSVD, 32'hFFFF_FFFF);
    reg_read(A_RSVD, 32'h0);
    reg_read(A_EVENT, 32'h0);
    reg_read(A_CTRL, 32'h1);

    // Overflow with drop: disabled, irq enabled, 9 writes into 8 entries
    reg_write(A_CTRL, 32'h4);
    for (int i = 0; i < int'(DEPTH) + 1; i++) evt_write(AER_W'($urandom), i < int'(DEPTH));
    chk("ovf_irq_set", 32'(irq), 32'd1);
    reg_read(A_STATUS, status_exp(DEPTH, 1'b1));
    reg_write(A_CTRL, 32'hC);
    chk("ovf_irq_clr", 32'(irq), 32'd0);
    reg_read(A_STATUS, status_exp(DEPTH, 1'b0));
    reg_read(A_CTRL, 32'h4);
    base = n_deliv;
    reg_write(A_CTRL, 32'h1);
    wait_drain("ovf");
    chk("ovf_delivered", 32'(n_deliv - base), 32'(DEPTH));
    reg_read(A_STATUS, status_exp(0, 1'b0));

    // Stall mode: receiver paused so the FIFO fills, ninth write must wait
    rx_pause = 1'b1;
    reg_write(A_CTRL, 32'h3);
    base = n_deliv;
    for (int i = 0; i < int'(DEPTH); i++) evt_write(AER_W'(32'h300 + i), 1'b1);
    obi_start(1'b1, A_EVENT, 32'h3FF);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("stall_gnt_low", 32'(rsp.gnt), 32'd0);
      @(negedge clk);
    end
    begin
      bit g;
      rx_pause = 1'b0;
      obi_finish(32'h0, g);
      if (g) exp_aer.push_back(AER_W'(10'h3FF));
    end
    wait_drain("stall");
    chk("stall_delivered", 32'(n_deliv - base), 32'(DEPTH + 1));
    reg_read(A_STATUS, status_exp(0, 1'b0));

    // Streaming with random ack delay across several pointer wraps
    base = n_deliv;
    for (int i = 0; i < 20; i++) begin
      evt_write(AER_W'(32'h100 + i), 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain("stream");
    chk("stream_delivered", 32'(n_deliv - base), 32'd20);

    // Reset in the middle of a handshake with ack held high
    reg_write(A_CTRL, 32'h1);
    rx_pause = 1'b1;
    evt_write(AER_W'(10'h155), 1'b1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = aer_req;
      end
      chk("rst_test_req_seen", 32'(seen), 32'd1);
    end
    rx_force = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_aer_req", 32'(aer_req), 32'd0);
    chk("mid_rst_aer_addr", 32'(aer_addr), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_rvalid", 32'(rsp.rvalid), 32'd0);
    rst = 1'b0;
    rx_pause = 1'b0;
    @(negedge clk);
    reg_read(A_STATUS, status_exp(0, 1'b0));
    reg_read(A_CTRL, 32'h0);
    reg_write(A_CTRL, 32'h1);
    evt_write(AER_W'(10'h0AA), 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_req_while_ack_high", 32'(aer_req), 32'd0);
    end
    rx_force = 1'b0;
    wait_drain("post_rst");
    reg_read(A_STATUS, status_exp(0, 1'b0));

    repeat (4) @(negedge clk);
    chk("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
    chk("aer_queue_empty", 32'(exp_aer.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
